// File: rtl/line_win_scanner.sv
// Sequential SIZE x SIZE line-win scanner: snapshots the board on start, tests one line per clock.
// Optional LINE_WIN_MULTI_EN: always scans all lines and flags boards with two or more winning lines.
module line_win_scanner #(
  parameter int SIZE = 3,
  localparam int NL = 2*SIZE + 2,
  localparam int LW = $clog2(2*SIZE + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2*SIZE*SIZE-1:0]   board,
  output logic                     busy,
  output logic                     done,
  output logic                     winner,
  output logic [1:0]               who_win,
  output logic [LW-1:0]            win_line,
  output logic                     draw
`ifdef LINE_WIN_MULTI_EN
  ,output logic                    multi_win
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [LW-1:0]            line_idx_reg, line_idx_next;
  logic [2*SIZE*SIZE-1:0]   snapshot_reg, snapshot_next;
  logic                     winner_reg, winner_next;
  logic [1:0]               who_win_reg, who_win_next;
  logic [LW-1:0]            win_line_reg, win_line_next;
  logic                     draw_reg, draw_next;
`ifdef LINE_WIN_MULTI_EN
  logic                     multi_reg, multi_next;
`endif

  logic [NL-1:0]            line_win;
  logic [1:0]               line_val [NL];
  logic                     board_full;

  // Per-line cell gather: rows, then columns, then main and anti diagonal.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_line
      logic [2*SIZE-1:0] cells;
      logic              same;
      for (gj = 0; gj < SIZE; gj++) begin : g_cell
        localparam int IDX = (gi < SIZE)   ? gi*SIZE + gj :
                             (gi < 2*SIZE) ? gj*SIZE + (gi - SIZE) :
                             (gi == 2*SIZE) ? gj*SIZE + gj :
                                              gj*SIZE + SIZE - 1 - gj;
        assign cells[2*gj +: 2] = snapshot_reg[2*IDX +: 2];
      end
      always_comb begin
        same = 1'b1;
        for (int j = 1; j < SIZE; j++) begin
          if (cells[2*j +: 2] != cells[1:0]) same = 1'b0;
        end
      end
      assign line_win[gi] = same && (cells[1:0] == 2'b01 || cells[1:0] == 2'b10);
      assign line_val[gi] = cells[1:0];
    end
  endgenerate

  // A cell is a real move only when exactly one of its two bits is set.
  always_comb begin
    board_full = 1'b1;
    for (int k = 0; k < SIZE*SIZE; k++) begin
      if (snapshot_reg[2*k] == snapshot_reg[2*k+1]) board_full = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      line_idx_reg <= '0;
      snapshot_reg <= '0;
      winner_reg   <= 1'b0;
      who_win_reg  <= 2'b00;
      win_line_reg <= '0;
      draw_reg     <= 1'b0;
`ifdef LINE_WIN_MULTI_EN
      multi_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      line_idx_reg <= line_idx_next;
      snapshot_reg <= snapshot_next;
      winner_reg   <= winner_next;
      who_win_reg  <= who_win_next;
      win_line_reg <= win_line_next;
      draw_reg     <= draw_next;
`ifdef LINE_WIN_MULTI_EN
      multi_reg    <= multi_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    line_idx_next = line_idx_reg;
    snapshot_next = snapshot_reg;
    winner_next   = winner_reg;
    who_win_next  = who_win_reg;
    win_line_next = win_line_reg;
    draw_next     = draw_reg;
`ifdef LINE_WIN_MULTI_EN
    multi_next    = multi_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          snapshot_next = board;
          line_idx_next = '0;
          winner_next   = 1'b0;
          who_win_next  = 2'b00;
          win_line_next = '0;
          draw_next     = 1'b0;
`ifdef LINE_WIN_MULTI_EN
          multi_next    = 1'b0;
`endif
          state_next    = SCAN;
        end
      end
      SCAN: begin
`ifdef LINE_WIN_MULTI_EN
        // Keep the first (lowest-index) win; any later win marks a multi-win board.
        if (line_win[line_idx_reg]) begin
          if (!winner_reg) begin
            winner_next   = 1'b1;
            who_win_next  = line_val[line_idx_reg];
            win_line_next = line_idx_reg;
          end else begin
            multi_next = 1'b1;
          end
        end
        if (line_idx_reg == LW'(NL-1)) begin
          draw_next  = !winner_next && board_full;
          state_next = DONE;
        end else begin
          line_idx_next = line_idx_reg + LW'(1);
        end
`else
        if (line_win[line_idx_reg]) begin
          winner_next   = 1'b1;
          who_win_next  = line_val[line_idx_reg];
          win_line_next = line_idx_reg;
          state_next    = DONE;
        end else if (line_idx_reg == LW'(NL-1)) begin
          draw_next  = board_full;
          state_next = DONE;
        end else begin
          line_idx_next = line_idx_reg + LW'(1);
        end
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign winner   = winner_reg;
  assign who_win  = who_win_reg;
  assign win_line = win_line_reg;
  assign draw     = draw_reg;
`ifdef LINE_WIN_MULTI_EN
  assign multi_win = multi_reg;
`endif

endmodule

// File: tb/tb_line_win_scanner.sv
// Directed self-checking bench for line_win_scanner (SIZE=3; SIZE=4 multi-win case when LINE_WIN_MULTI_EN).
module tb_line_win_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] board = '0;
  logic        busy, done, winner, draw;
  logic [1:0]  who_win;
  logic [2:0]  win_line;
`ifdef LINE_WIN_MULTI_EN
  logic        multi_win;
  localparam bit EARLY = 1'b0;
  logic        start4 = 1'b0;
  logic [31:0] board4 = '0;
  logic        busy4, done4, winner4, draw4, multi_win4;
  logic [1:0]  who_win4;
  logic [3:0]  win_line4;
`else
  localparam bit EARLY = 1'b1;
`endif

  int pass_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  line_win_scanner #(.SIZE(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .board(board),
    .busy(busy), .done(done), .winner(winner), .who_win(who_win),
    .win_line(win_line), .draw(draw)
`ifdef LINE_WIN_MULTI_EN
    , .multi_win(multi_win)
`endif
  );

`ifdef LINE_WIN_MULTI_EN
  line_win_scanner #(.SIZE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .board(board4),
    .busy(busy4), .done(done4), .winner(winner4), .who_win(who_win4),
    .win_line(win_line4), .draw(draw4), .multi_win(multi_win4)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] b9(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  function automatic int exp_done(input int line);
    return EARLY ? line + 2 : 9;
  endfunction

  // Start a scan and watch cycles 1..12; optionally re-pulse start with a new board in cycles 1-2.
  task automatic scan(input logic [17:0] b, input bit interfere, output int dc, output int nd,
                      output logic [3:1] bh, output logic w1);
    @(negedge clk);
    board = b;
    start = 1'b1;
    dc = -1;
    nd = 0;
    bh = '0;
    w1 = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (dc < 0) dc = k;
      end
      if (k <= 3) bh[k] = busy;
      if (k == 1) w1 = winner;
      if (interfere && k <= 2) begin
        start = 1'b1;
        board = '0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic w, input logic [1:0] who,
                           input logic [2:0] line, input logic d);
    check({tag, ".winner"}, winner, w);
    check({tag, ".who_win"}, who_win, who);
    check({tag, ".win_line"}, win_line, line);
    check({tag, ".draw"}, draw, d);
    $display("scan %s: winner=%0d who_win=%0d win_line=%0d draw=%0d", tag, winner, who_win, win_line, draw);
  endtask

  initial begin
    int dc, nd;
    logic [3:1] bh;
    logic w1;
    logic [17:0] full_b;

    @(negedge clk);
    check("reset_outputs", {busy, done, winner, who_win, win_line, draw}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Row 0 won by player 1, with start re-pulsed and board changed while busy
    scan(b9(1,1,1,0,0,0,0,0,0), 1'b1, dc, nd, bh, w1);
    check("t1.done_cycle", dc, exp_done(0));
    check("t1.done_count", nd, 1);
    check("t1.cleared_c1", w1, 1'b0);
    check("t1.busy_c1", bh[1], 1'b1);
    check("t1.busy_c2", bh[2], 1'b1);
    if (EARLY) check("t1.busy_c3", bh[3], 1'b0);
    check_res("t1", 1'b1, 2'b01, 3'd0, 1'b0);
`ifdef LINE_WIN_MULTI_EN
    check("t1.multi_win", multi_win, 1'b0);
`endif

    // Anti-diagonal won by player 2 (last line)
    scan(b9(1,0,2,0,2,1,2,1,0), 1'b0, dc, nd, bh, w1);
    check("t2.done_cycle", dc, 9);
    check("t2.done_count", nd, 1);
    check_res("t2", 1'b1, 2'b10, 3'd7, 1'b0);

    // Full board, no line: draw; previous win must be cleared on start
    full_b = b9(1,2,1,1,2,2,2,1,1);
    scan(full_b, 1'b0, dc, nd, bh, w1);
    check("t3.done_cycle", dc, 9);
    check("t3.cleared_c1", w1, 1'b0);
    check_res("t3", 1'b0, 2'b00, 3'd0, 1'b1);

    // Same board with an invalid cell: no draw
    scan(b9(1,2,1,1,2,2,2,1,3), 1'b0, dc, nd, bh, w1);
    check("t3b.done_cycle", dc, 9);
    check_res("t3b", 1'b0, 2'b00, 3'd0, 1'b0);

    // Invalid cell breaks an otherwise uniform row
    scan(b9(0,0,0,1,3,1,0,0,0), 1'b0, dc, nd, bh, w1);
    check("t4.done_cycle", dc, 9);
    check_res("t4", 1'b0, 2'b00, 3'd0, 1'b0);

    // Row 2 and column 2 both won: lowest index reported
    scan(b9(0,0,1,0,0,1,1,1,1), 1'b0, dc, nd, bh, w1);
    check("t5.done_cycle", dc, exp_done(2));
    check_res("t5", 1'b1, 2'b01, 3'd2, 1'b0);
`ifdef LINE_WIN_MULTI_EN
    check("t5.multi_win", multi_win, 1'b1);
`endif

    // Reset in cycle 4 of a full scan: outputs drop at once, no done follows
    @(negedge clk);
    board = full_b;
    start = 1'b1;
    nd = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) nd++;
      if (k == 4) begin
        check("rst.busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst.outputs", {busy, done, winner, who_win, win_line, draw}, '0);
      end
      if (k == 5) rst = 1'b0;
    end
    check("rst.no_done", nd, 0);
    $display("scan rst: aborted, done pulses=%0d", nd);

`ifdef LINE_WIN_MULTI_EN
    // SIZE=4: row 0 and column 0 both won by player 1
    @(negedge clk);
    board4 = '0;
    for (int c = 0; c < 4; c++) board4[2*c +: 2] = 2'b01;
    for (int r = 0; r < 4; r++) board4[2*(4*r) +: 2] = 2'b01;
    start4 = 1'b1;
    dc = -1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4 && dc < 0) dc = k;
    end
    check("m4.done_cycle", dc, 11);
    check("m4.winner", winner4, 1'b1);
    check("m4.win_line", win_line4, 4'd0);
    check("m4.multi_win", multi_win4, 1'b1);
    $display("scan m4: done@%0d win_line=%0d multi_win=%0d", dc, win_line4, multi_win4);
`endif

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule

// File: doc/line_win_scanner.md
Name: line_win_scanner

Overview:
- Sequential, parametrised successor to the team's fixed 3x3 win detector.
- Captures a SIZE x SIZE board snapshot on a start pulse, then scans every winning line, one line per clock.
- A line is won when all of its SIZE cells hold the same player.
- Reports the winner, the winning player, the winning line index and a draw flag through a start/done handshake; sits between the move controller and the display/score logic.

Parameters:
- SIZE, 3, board edge length (3..8); a win is SIZE cells in a row.
- NL, 2*SIZE+2, number of lines (derived localparam; do not override).
- LW, $clog2(2*SIZE+2), width of win_line (derived localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request scan; sampled only in IDLE.
- board  in  2*SIZE*SIZE  cell i = r*SIZE+c at bits [2i+1:2i]; 00 empty, 01 player1, 10 player2, 11 invalid.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; results valid from this cycle.
- winner  out  1  a winning line was found.
- who_win  out  2  winning player code (01/10); 00 if no win.
- win_line  out  LW  index of the reported winning line; 0 if no win.
- draw  out  1  no win and every cell is 01 or 10.

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE, line_idx=0, snapshot=0.
  - busy=0, done=0, winner=0, who_win=00, win_line=0, draw=0.
  - A scan in progress is abandoned; no done pulse is issued.
- Line order:
  - Rows 0..SIZE-1 are lines 0..SIZE-1.
  - Columns 0..SIZE-1 are lines SIZE..2SIZE-1.
  - Main diagonal (cells r*SIZE+r) is line 2SIZE.
  - Anti-diagonal (cells r*SIZE+SIZE-1-r) is line 2SIZE+1.
- Line win test: all cells equal AND cell != 00 AND cell != 11. Any 11 cell in a line means that line is not a win.
- IDLE:
  - On start=1 (edge at cycle 0): latch board into snapshot, line_idx=0, clear winner/who_win/win_line/draw, go to SCAN.
  - board is not sampled again until the next accepted start.
- SCAN: line line_idx is evaluated against the snapshot, so line i is evaluated in cycle i+1.
  - Win on line i: register winner=1, who_win=cell value, win_line=i; go to DONE (early exit).
  - No win and line_idx==NL-1: winner=0; draw=1 iff no snapshot cell is 00 or 11; go to DONE.
  - Otherwise line_idx++.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - First win on line i: done asserted in cycle i+2.
  - No win: done asserted in cycle NL+1 (cycle 9 for SIZE=3).
- Result outputs hold their values after DONE until the next accepted start clears them.
- start while busy=1, including in the DONE cycle, is ignored; it is neither queued nor does it retrigger.
- Changes on board during SCAN have no effect.
- At most one player's code is reported. With early exit, the lowest-index winning line wins.

Optional Feature:
- Macro LINE_WIN_MULTI_EN.
- Defined:
  - No early exit; all NL lines are always scanned, and done is always in cycle NL+1.
  - Extra output port multi_win (1 bit) is asserted at done if two or more lines are won by either player.
  - win_line and who_win report the lowest-index winning line; multi_win resets to 0 and clears on start.
- Undefined: early exit as above; multi_win port absent.

Test Plan:
- SIZE=3, board cells 0,1,2=01, rest 00; start at cycle 0 -> done at cycle 2, winner=1, who_win=01, win_line=0, draw=0, busy high in cycles 1-2.
- SIZE=3, cells 2,4,6=10, others alternating non-winning 01/00 -> done at cycle 9, winner=1, who_win=10, win_line=7.
- SIZE=3, full board 01,10,01 / 01,10,10 / 10,01,01 -> done at cycle 9, winner=0, who_win=00, draw=1; same board with cell 8=11 -> draw=0.
- SIZE=3, cells 3,4,5 = 01,11,01 -> line 1 not won; winner=0 at cycle 9.
- Start row-0 win, pulse start again at cycle 1 and change board -> single done at cycle 2 using original snapshot; rst asserted at cycle 4 of a full scan -> all outputs 0 immediately, no done pulse.
- SIZE=4 with LINE_WIN_MULTI_EN, row 0 and column 0 all 01 -> done at cycle 11, win_line=0, multi_win=1.
